// File: rtl/dice_display_scheduler.sv
// Two-digit 7-segment multiplexer: alternates ones/tens commons with dead time between slots.
// New digit values are accepted only during the second gap, so each frame shows one coherent value.
module dice_display_scheduler #(
  parameter int unsigned SLOT_CYCLES  = 1024,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       value_valid,
  input  logic [3:0] value_ones,
  input  logic [3:0] value_tens,
  output logic       value_ready,
  input  logic       seg_pol,
  input  logic       com_pol,
  input  logic       blank_lz,
  output logic [7:0] seg_out,
  output logic [1:0] com_out,
  output logic [1:0] com_oe
);

  typedef enum logic [1:0] {StOnes, StGap1, StTens, StGap2} state_e;

  localparam logic [15:0] SlotLast  = 16'(SLOT_CYCLES - 1);
  localparam logic [15:0] BlankLast = 16'(BLANK_CYCLES - 1);

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic        r_run;
  logic [3:0]  r_ones, r_tens, w_ones_d, w_tens_d;
  logic [7:0]  r_seg, w_seg_d;
  logic [1:0]  r_com, w_com_d;
  logic [1:0]  r_oe, w_oe_d;
  logic        w_last;
  logic [7:0]  w_pat;

  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'h3F;
      4'd1:    p = 8'h06;
      4'd2:    p = 8'h5B;
      4'd3:    p = 8'h4F;
      4'd4:    p = 8'h66;
      4'd5:    p = 8'h6D;
      4'd6:    p = 8'h7D;
      4'd7:    p = 8'h07;
      4'd8:    p = 8'h7F;
      4'd9:    p = 8'h6F;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  assign value_ready = r_run && (r_state == StGap2);

  // Digit load and dwell sequencing
  always_comb begin
    w_ones_d  = r_ones;
    w_tens_d  = r_tens;
    if (value_valid && value_ready) begin
      w_ones_d = value_ones;
      w_tens_d = value_tens;
    end

    w_last    = ((r_state == StOnes) || (r_state == StTens)) ? (r_cnt == SlotLast)
                                                             : (r_cnt == BlankLast);
    w_state_d = r_state;
    w_cnt_d   = r_cnt + 16'd1;
    // Both a stopped scheduler and one stopping now park at the start of the accept window.
    if (!r_run || !ena) begin
      w_state_d = StGap2;
      w_cnt_d   = 16'd0;
    end else if (w_last) begin
      w_cnt_d = 16'd0;
      unique case (r_state)
        StOnes:  w_state_d = StGap1;
        StGap1:  w_state_d = StTens;
        StTens:  w_state_d = StGap2;
        default: w_state_d = StOnes;
      endcase
    end
  end

  // Outputs are computed from next-state values so they switch together with the state
  always_comb begin
    w_pat   = 8'h00;
    w_seg_d = {8{~seg_pol}};
    w_com_d = {2{~com_pol}};
    w_oe_d  = ena ? 2'b11 : 2'b00;
    if (ena) begin
      if (w_state_d == StOnes) begin
        w_pat   = seg_pattern(w_ones_d);
        w_seg_d = seg_pol ? w_pat : ~w_pat;
        w_com_d = {~com_pol, com_pol};
      end else if (w_state_d == StTens) begin
        if (!(blank_lz && (w_tens_d == 4'd0))) begin
          w_pat   = seg_pattern(w_tens_d);
          w_com_d = {com_pol, ~com_pol};
        end
        w_seg_d = seg_pol ? w_pat : ~w_pat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StGap2;
      r_cnt   <= 16'd0;
      r_run   <= 1'b0;
      r_ones  <= 4'hF;
      r_tens  <= 4'hF;
      r_seg   <= 8'h00;
      r_com   <= 2'b00;
      r_oe    <= 2'b00;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_run   <= ena;
      r_ones  <= w_ones_d;
      r_tens  <= w_tens_d;
      r_seg   <= w_seg_d;
      r_com   <= w_com_d;
      r_oe    <= w_oe_d;
    end
  end

  assign seg_out = r_seg;
  assign com_out = r_com;
  assign com_oe  = r_oe;

endmodule

// File: tb/tb_dice_display_scheduler.sv
// Bench for dice_display_scheduler: a frame-position model pushes expected outputs per edge,
// which are popped and compared after each edge.
module tb_dice_display_scheduler;

  localparam int Slot   = 4;
  localparam int Blank  = 2;
  localparam int Frame  = 2 * (Slot + Blank);
  localparam int GapTwo = Frame - Blank;
  localparam int TensLo = Slot + Blank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       value_valid = 1'b0;
  logic [3:0] value_ones = 4'd0;
  logic [3:0] value_tens = 4'd0;
  logic       value_ready;
  logic       seg_pol = 1'b1;
  logic       com_pol = 1'b0;
  logic       blank_lz = 1'b0;
  logic [7:0] seg_out;
  logic [1:0] com_out;
  logic [1:0] com_oe;

  always #5 clk = ~clk;

  dice_display_scheduler #(
    .SLOT_CYCLES (Slot),
    .BLANK_CYCLES(Blank)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .value_valid(value_valid),
    .value_ones (value_ones),
    .value_tens (value_tens),
    .value_ready(value_ready),
    .seg_pol    (seg_pol),
    .com_pol    (com_pol),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .com_out    (com_out),
    .com_oe     (com_oe)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [1:0] com;
    logic [1:0] oe;
    logic       rdy;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_ready = 0;
  int         m_pos = GapTwo;
  bit         m_run = 1'b0;
  logic [3:0] m_ones = 4'hF;
  logic [3:0] m_tens = 4'hF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 8'h3F;
      4'd1: return 8'h06;
      4'd2: return 8'h5B;
      4'd3: return 8'h4F;
      4'd4: return 8'h66;
      4'd5: return 8'h6D;
      4'd6: return 8'h7D;
      4'd7: return 8'h07;
      4'd8: return 8'h7F;
      4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [7:0] p;
    e.rdy = m_run && (m_pos >= GapTwo);
    e.oe  = m_run ? 2'b11 : 2'b00;
    e.seg = {8{~seg_pol}};
    e.com = {2{~com_pol}};
    if (m_run && m_pos < Slot) begin
      p     = pat(m_ones);
      e.seg = seg_pol ? p : ~p;
      e.com = {~com_pol, com_pol};
    end else if (m_run && m_pos >= TensLo && m_pos < GapTwo) begin
      p = 8'h00;
      if (!(blank_lz && m_tens == 4'd0)) begin
        p     = pat(m_tens);
        e.com = {com_pol, ~com_pol};
      end
      e.seg = seg_pol ? p : ~p;
    end
    return e;
  endfunction

  // Advance the model with the inputs presented for the coming edge, then compare after it.
  task automatic tick();
    exp_t e;
    if (!rst_n) begin
      m_run  = 1'b0;
      m_pos  = GapTwo;
      m_ones = 4'hF;
      m_tens = 4'hF;
      e      = '0;
    end else begin
      if (value_valid && m_run && m_pos >= GapTwo) begin
        m_ones = value_ones;
        m_tens = value_tens;
      end
      if (!ena) begin
        m_run = 1'b0;
        m_pos = GapTwo;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_pos = GapTwo;
      end else begin
        m_pos = (m_pos + 1) % Frame;
      end
      e = expect_now();
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("seg_out", 32'(seg_out), 32'(e.seg));
    check("com_out", 32'(com_out), 32'(e.com));
    check("com_oe", 32'(com_oe), 32'(e.oe));
    check("value_ready", 32'(value_ready), 32'(e.rdy));
    if (value_ready) n_ready++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_value(input logic [3:0] tens, input logic [3:0] ones);
    bit acc;
    bit done = 1'b0;
    value_valid = 1'b1;
    value_tens  = tens;
    value_ones  = ones;
    for (int k = 0; k < 3 * Frame && !done; k++) begin
      acc = m_run && (m_pos >= GapTwo);
      tick();
      done = acc;
    end
    value_valid = 1'b0;
    if (!done) check("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_to_pos(input int p);
    for (int k = 0; k < 2 * Frame && m_pos != p; k++) tick();
    check("reach_pos", 32'(m_pos), 32'(p));
  endtask

  initial begin
    #1;
    check("rst_seg", 32'(seg_out), 32'h00);
    check("rst_com", 32'(com_out), 32'h0);
    check("rst_oe", 32'(com_oe), 32'h0);
    check("rst_ready", 32'(value_ready), 32'h0);
    ticks(2);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Basic display of 4/2 and one-frame accept window count
    load_value(4'd4, 4'd2);
    ticks(Frame);
    n_ready = 0;
    ticks(Frame);
    check("ready_per_frame", 32'(n_ready), 32'd2);

    // Offers outside GAP2 are ignored; last in-window offer wins
    value_valid = 1'b1;
    n_ready = 0;
    for (int i = 0; i < 2 * Frame; i++) begin
      if (m_pos >= GapTwo - 1 && m_pos < Frame - 1) begin
        value_tens = 4'd1;
        value_ones = 4'd3;
      end else begin
        value_tens = 4'd0;
        value_ones = 4'd7;
      end
      tick();
    end
    value_valid = 1'b0;
    check("ready_two_frames", 32'(n_ready), 32'd4);
    ticks(Frame);

    // Leading-zero suppression on and off
    blank_lz = 1'b1;
    load_value(4'd0, 4'd5);
    ticks(Frame);
    blank_lz = 1'b0;
    ticks(Frame);

    // Inverted polarities and a blank tens code
    seg_pol = 1'b0;
    com_pol = 1'b1;
    load_value(4'd10, 4'd9);
    ticks(Frame);

    // Polarity change mid-slot
    run_to_pos(1);
    seg_pol = 1'b1;
    ticks(2);
    com_pol = 1'b0;
    ticks(Frame);

    // Drop ena during TENS, then restart
    run_to_pos(TensLo + 1);
    ena = 1'b0;
    tick();
    check("ena_drop_oe", 32'(com_oe), 32'h0);
    ticks(3);
    ena = 1'b1;
    n_ready = 0;
    ticks(Blank);
    check("restart_window", 32'(n_ready), 32'(Blank));
    ticks(Frame);

    // Asynchronous reset mid-slot, then a blank frame with no handshake
    run_to_pos(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg_out), 32'h00);
    check("async_com", 32'(com_out), 32'h0);
    check("async_oe", 32'(com_oe), 32'h0);
    check("async_ready", 32'(value_ready), 32'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2 * Frame);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dice_display_scheduler.md
DICE_DISPLAY_SCHEDULER -- requirements
Module: dice_display_scheduler

Interface
REQ-001 Parameter SLOT_CYCLES, default 1024, number of clock cycles each digit is driven; legal range 1..65535.
REQ-002 Parameter BLANK_CYCLES, default 16, number of clock cycles of dead time after each digit slot; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  scheduler enable; high = multiplexing runs.
REQ-006 value_valid  input  1  new two-digit value offered.
REQ-007 value_ones  input  4  BCD ones digit; codes 10..15 mean blank.
REQ-008 value_tens  input  4  BCD tens digit; codes 10..15 mean blank.
REQ-009 value_ready  output  1  scheduler accepts a value this cycle.
REQ-010 seg_pol  input  1  level of a lit segment on seg_out.
REQ-011 com_pol  input  1  level of an active common on com_out.
REQ-012 blank_lz  input  1  suppress a leading zero on the tens digit.
REQ-013 seg_out  output  8  segments, bit0=a .. bit6=g, bit7=dp.
REQ-014 com_out  output  2  bit0 = ones common, bit1 = tens common.
REQ-015 com_oe  output  2  output enables for com_out.

Function
REQ-016 State machine states ONES, GAP1, TENS, GAP2; fixed cycle order ONES -> GAP1 -> TENS -> GAP2 -> ONES.
REQ-017 ONES and TENS each last exactly SLOT_CYCLES cycles; GAP1 and GAP2 each last exactly BLANK_CYCLES cycles; frame = 2*(SLOT_CYCLES+BLANK_CYCLES) cycles.
REQ-018 A run flag register follows ena each clock; while run=0 the state is forced to GAP2 with the dwell counter cleared.
REQ-019 value_ready = run AND state==GAP2, combinational.
REQ-020 On a clock edge with value_valid=1 and value_ready=1, value_ones/value_tens load into the display digit registers; several handshakes within one GAP2 -> last one wins; value_valid outside GAP2 is ignored and not queued.
REQ-021 Digit registers change only in GAP2, so no frame ever shows a mix of old and new digits.
REQ-022 Segment patterns (lit=1, dp=0): 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F; codes 10..15 = 0x00.
REQ-023 seg_out, com_out, com_oe are registered, computed from the next state and next digit values, so they change on the same edge as the state.
REQ-024 In ONES: com_out[0] = com_pol, com_out[1] = ~com_pol, seg_out = pattern(ones) if seg_pol=1, else ~pattern(ones).
REQ-025 In TENS: com_out[1] = com_pol, com_out[0] = ~com_pol, seg_out = pattern(tens) with the same polarity rule as ones.
REQ-026 If blank_lz=1 and the tens digit is 0, TENS drives com_out = {2{~com_pol}} and the tens pattern is 0x00; slot length is unchanged.
REQ-027 In GAP1, GAP2 and while run=0: com_out = {2{~com_pol}}, seg_out = {8{~seg_pol}}; both commons are never active simultaneously.
REQ-028 com_oe = 2'b11 while run=1, 2'b00 while run=0.
REQ-029 ena falling mid-frame: on the next edge run=0, outputs go inactive per REQ-027/028, and the digit registers are kept.
REQ-030 ena rising: scheduler starts at GAP2 with counter 0, giving a full BLANK_CYCLES accept window before ONES.
REQ-031 seg_pol, com_pol and blank_lz are sampled every cycle; a change takes effect on the next output register update, including mid-slot.

Reset
REQ-032 While rst_n=0: state=GAP2, counter=0, run=0, both digit registers=4'hF, seg_out=8'h00, com_out=2'b00, com_oe=2'b00, value_ready=0.
REQ-033 Reset assertion mid-frame aborts immediately and asynchronously; any handshake in the reset cycle is lost.
REQ-034 After deassertion with no handshake, a frame shows both digits blank: commons cycle, segments are all unlit.

Verification (SLOT_CYCLES=4, BLANK_CYCLES=2)
REQ-035 Reset, ena=1, offer 4/2 (tens/ones), seg_pol=1, com_pol=0 -> accepted in the first GAP2; then com_out=2'b10 and seg_out=0x5B for 4 cycles, 2 gap cycles with 2'b11/0x00, com_out=2'b01 and seg_out=0x66 for 4 cycles; frame length is 12 cycles.
REQ-036 Hold value_valid high with 0/7 during ONES/TENS, then with 1/3 in GAP2 -> only 1/3 is displayed; value_ready is high in exactly 2 of every 12 cycles.
REQ-037 Value 0/5 with blank_lz=1 -> the tens slot has both commons inactive; with blank_lz=0 it shows 0x3F.
REQ-038 seg_pol=0, com_pol=1, value 10/9 -> ones slot: seg_out=~0x6F=0x90 and com_out=2'b01; tens slot: seg_out=0xFF.
REQ-039 Drop ena during TENS -> next edge com_oe=00, outputs inactive; raise ena -> value_ready is high for 2 cycles, then ONES with the retained digits.
REQ-040 Assert rst_n=0 mid-slot, asynchronously -> outputs take REQ-032 values without waiting for a clock edge.
